// File: rtl/pulse_stretcher.sv
// Stretches one-clock event pulses into visible LED blinks (ON high, GAP low) and queues
// pulses that arrive mid-blink. Define PULSE_STRETCHER_OVF_EN to build the sticky overflow flag.
module pulse_stretcher #(
    parameter int ON_CYCLES   = 5_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int QUEUE_DEPTH = 15,
    parameter int CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic             led,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int MAX_T = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TMR_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    if (ON_CYCLES < 1) begin : g_bad_on
        $error("pulse_stretcher: ON_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("pulse_stretcher: GAP_CYCLES must be >= 1");
    end
    if (QUEUE_DEPTH < 1) begin : g_bad_depth
        $error("pulse_stretcher: QUEUE_DEPTH must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [TMR_W-1:0]   timer, timer_next;
    logic [CNT_W-1:0]   pending_next;
    logic               led_next;
    logic               have_queued;
    logic               start;
    logic               take_queue;
    logic               take_direct;
    logic               enqueue;
    logic               saturated;

    // A start prefers the queue so blinks play out in arrival order.
    always_comb begin
        have_queued = (pending != '0);
        start       = (have_queued || pulse_in) &&
                      ((state == IDLE) || ((state == GAP) && (timer == '0)));
        take_queue  = start && have_queued;
        take_direct = start && !have_queued;
        enqueue     = pulse_in && !take_direct;
        saturated   = (pending == CNT_W'(QUEUE_DEPTH));
    end

    always_comb begin
        pending_next = pending;
        if (enqueue && !take_queue && !saturated) begin
            pending_next = pending + CNT_W'(1);
        end else if (take_queue && !enqueue) begin
            pending_next = pending - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ON;
                    timer_next = TMR_W'(ON_CYCLES - 1);
                end
            end
            ON: begin
                if (timer == '0) begin
                    state_next = GAP;
                    timer_next = TMR_W'(GAP_CYCLES - 1);
                end else begin
                    timer_next = timer - TMR_W'(1);
                end
            end
            GAP: begin
                if (timer == '0) begin
                    if (start) begin
                        state_next = ON;
                        timer_next = TMR_W'(ON_CYCLES - 1);
                    end else begin
                        state_next = IDLE;
                        timer_next = '0;
                    end
                end else begin
                    timer_next = timer - TMR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
        led_next = (state_next == ON);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            pending <= '0;
            led     <= 1'b0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            pending <= pending_next;
            led     <= led_next;
        end
    end

    assign busy = (state != IDLE) || (pending != '0);

`ifdef PULSE_STRETCHER_OVF_EN
    logic dropped;
    logic ovf_q;

    assign dropped = enqueue && !take_queue && saturated;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (dropped) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
